// File: rtl/pipe_ctrl_if.sv
// Control bundle between the pipeline stages and the central sequencer.
// Carries stall requests and exception reports one way, and stall/flush/redirect back.
// Purely combinational wiring; the sequencer owns all timing.
interface pipe_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             stallreq_if;
    logic             stallreq_id;
    logic             stallreq_ex;
    logic             stallreq_mem;
    logic [31:0]      excepttype_i;
    logic [31:0]      mtvec_i;
    logic [31:0]      mepc_i;
    logic [5:0]       stall;
    logic             flush;
    logic [31:0]      new_pc;
    logic             wdog_trap_o;
    logic [CNT_W-1:0] stall_cnt_o;

    // Pipeline side: raises requests and reports, obeys stall/flush.
    modport master (
        output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
        output excepttype_i, mtvec_i, mepc_i,
        input  stall, flush, new_pc, wdog_trap_o, stall_cnt_o
    );

    // Sequencer side.
    modport slave (
        input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
        input  excepttype_i, mtvec_i, mepc_i,
        output stall, flush, new_pc, wdog_trap_o, stall_cnt_o
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: merges stall requests, turns MEM exceptions/watchdog into flush+redirect.
// Latency: stall is same-cycle combinational; flush/new_pc registered, one cycle after the report.
// Backpressure: stall freezes the requesting stage and all younger ones; FLUSH cycle overrides stall.
module pipe_ctrl #(
    parameter int WDOG_LIMIT = 1024,
    parameter int CNT_W      = 32
) (
    input  logic        clk,
    input  logic        rst,
    pipe_ctrl_if.slave  io_ctrl
);

    // The counter only has to reach WDOG_LIMIT-1 before the watchdog fires.
    localparam int              WD_W     = (WDOG_LIMIT < 2) ? 1 : $clog2(WDOG_LIMIT);
    localparam bit              WD_EN    = (WDOG_LIMIT != 0);
    localparam logic [WD_W-1:0] WD_LAST  = (WDOG_LIMIT == 0) ? '0 : WD_W'(WDOG_LIMIT - 1);
    localparam logic [31:0]     EXC_MRET = 32'h0000000e;

    // Stall masks: the requesting stage and every stage behind it stop.
    localparam logic [5:0] STALL_MEM  = 6'b011111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_IF   = 6'b000011;
    localparam logic [5:0] STALL_NONE = 6'b000000;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_flush;
    logic             w_flush_nxt;
    logic             r_wdog_trap;
    logic             w_wdog_trap_nxt;
    logic [31:0]      r_new_pc;
    logic [31:0]      w_new_pc_nxt;
    logic [WD_W-1:0]  r_wd_cnt;
    logic [WD_W-1:0]  w_wd_cnt_nxt;
    logic [CNT_W-1:0] r_stall_cnt;

    logic             w_any_req;
    logic [5:0]       w_stall_prio;
    logic [5:0]       w_stall;
    logic             w_exc;
    logic             w_wd_fire;
    logic [31:0]      w_exc_pc;

    assign w_any_req = io_ctrl.stallreq_if | io_ctrl.stallreq_id |
                       io_ctrl.stallreq_ex | io_ctrl.stallreq_mem;

    // Fixed-priority stall merge: the oldest stalling stage decides the mask.
    always_comb begin
        w_stall_prio = STALL_NONE;
        if (io_ctrl.stallreq_mem) begin
            w_stall_prio = STALL_MEM;
        end else if (io_ctrl.stallreq_ex) begin
            w_stall_prio = STALL_EX;
        end else if (io_ctrl.stallreq_id) begin
            w_stall_prio = STALL_ID;
        end else if (io_ctrl.stallreq_if) begin
            w_stall_prio = STALL_IF;
        end
    end

    // Nothing stalls while in reset or while the flush cycle clears the pipe.
    always_comb begin
        w_stall = w_stall_prio;
        if (!rst || (r_state == ST_FLUSH)) begin
            w_stall = STALL_NONE;
        end
    end

    // Reports are only honoured in RUN so a held report cannot retrigger during FLUSH.
    assign w_exc     = (r_state == ST_RUN) && (io_ctrl.excepttype_i != 32'd0);
    assign w_wd_fire = WD_EN && (r_state == ST_RUN) && w_any_req && (r_wd_cnt == WD_LAST);
    assign w_exc_pc  = (io_ctrl.excepttype_i == EXC_MRET) ? io_ctrl.mepc_i : io_ctrl.mtvec_i;

    // Next-state: exception beats watchdog; FLUSH always lasts exactly one cycle.
    always_comb begin
        w_state_nxt     = r_state;
        w_flush_nxt     = 1'b0;
        w_wdog_trap_nxt = 1'b0;
        w_new_pc_nxt    = r_new_pc;
        w_wd_cnt_nxt    = r_wd_cnt;
        unique case (r_state)
            ST_RUN: begin
                if (w_exc) begin
                    w_state_nxt  = ST_FLUSH;
                    w_flush_nxt  = 1'b1;
                    w_new_pc_nxt = w_exc_pc;
                    w_wd_cnt_nxt = '0;
                end else if (w_wd_fire) begin
                    w_state_nxt     = ST_FLUSH;
                    w_flush_nxt     = 1'b1;
                    w_wdog_trap_nxt = 1'b1;
                    w_new_pc_nxt    = io_ctrl.mtvec_i;
                    w_wd_cnt_nxt    = '0;
                end else if (WD_EN && w_any_req) begin
                    w_wd_cnt_nxt = r_wd_cnt + WD_W'(1);
                end else begin
                    w_wd_cnt_nxt = '0;
                end
            end
            ST_FLUSH: begin
                w_state_nxt  = ST_RUN;
                w_wd_cnt_nxt = '0;
            end
            default: begin
                w_state_nxt  = ST_RUN;
                w_wd_cnt_nxt = '0;
            end
        endcase
    end

    // State and registered outputs; reset drops flush immediately, even mid-flush.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_RUN;
            r_flush     <= 1'b0;
            r_wdog_trap <= 1'b0;
            r_new_pc    <= 32'd0;
            r_wd_cnt    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_flush     <= w_flush_nxt;
            r_wdog_trap <= w_wdog_trap_nxt;
            r_new_pc    <= w_new_pc_nxt;
            r_wd_cnt    <= w_wd_cnt_nxt;
        end
    end

    // Saturating count of cycles in which any stage was held.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
        end else if ((w_stall != STALL_NONE) && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign io_ctrl.stall       = w_stall;
    assign io_ctrl.flush       = r_flush;
    assign io_ctrl.new_pc      = r_new_pc;
    assign io_ctrl.wdog_trap_o = r_wdog_trap;
    assign io_ctrl.stall_cnt_o = r_stall_cnt;

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central pipeline sequencer for the RV32I core.
- Merges per-stage stall requests into the 6-bit `stall` vector consumed by the pc, if_id, id_ex, ex_mem and mem_wb registers.
- Turns exceptions reported from MEM into a registered one-cycle `flush` plus a redirect PC.
- Adds a stall watchdog that forces a trap when the pipeline is frozen too long, and a saturating stall-cycle performance counter.

Parameters:
- WDOG_LIMIT, 1024, consecutive stall cycles before a forced trap; 0 disables the watchdog.
- CNT_W, 32, width of the stall performance counter.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-low (rst==0 resets).
- stallreq_if  in  1  instruction fetch waiting on bus.
- stallreq_id  in  1  load-use hazard in ID.
- stallreq_ex  in  1  multi-cycle EX op busy (div).
- stallreq_mem  in  1  data bus wait in MEM.
- excepttype_i  in  32  exception code from MEM; 0 = none.
- mtvec_i  in  32  trap vector base.
- mepc_i  in  32  saved PC for mret.
- stall  out  6  bit0 pc, bit1 if_id, bit2 id_ex, bit3 ex_mem, bit4 mem_wb, bit5 wb; 1 = Stop.
- flush  out  1  clear all pipeline registers this cycle.
- new_pc  out  32  redirect target, valid while flush=1.
- wdog_trap_o  out  1  one-cycle pulse, flush caused by watchdog.
- stall_cnt_o  out  CNT_W  cycles with stall!=0, saturating.

Behaviour:
- Reset (rst low, async):
  - state=RUN; flush=0, new_pc=0, wdog_trap_o=0, wd_cnt=0, stall_cnt_o=0.
  - stall forced to 6'b000000 while rst low.
- stall is combinational, same-cycle from the requests, fixed priority:
  - mem → 6'b011111
  - else ex → 6'b001111
  - else id → 6'b000111
  - else if → 6'b000011
  - else 6'b000000
- In state FLUSH, stall=0 regardless of requests.
- FSM has two states, RUN and FLUSH.
- RUN → FLUSH at an edge where excepttype_i!=0.
  - Registered in that edge: flush=1 and new_pc.
  - new_pc = mepc_i if excepttype_i==32'h0000000e (mret), else mtvec_i.
  - Latency: exception visible at cycle N gives flush=1 in cycle N+1.
- RUN → FLUSH also when the watchdog fires: new_pc=mtvec_i, wdog_trap_o=1.
- FLUSH → RUN unconditionally after one cycle; flush, wdog_trap_o return to 0; new_pc holds its last value.
- excepttype_i is ignored while in FLUSH; no back-to-back flush from the same report.
- Watchdog:
  - wd_cnt increments each RUN cycle with any stallreq high; clears on any RUN cycle with none, and on entering FLUSH.
  - When wd_cnt==WDOG_LIMIT-1 and a request is still high, the watchdog fires at that edge (stall held WDOG_LIMIT cycles).
  - WDOG_LIMIT=0: never fires, wd_cnt held at 0.
- Exception and watchdog fire on the same edge: the exception wins.
  - new_pc follows the exception rule; wdog_trap_o=0; wd_cnt cleared.
- stall_cnt_o:
  - Increments on each edge where the combinational stall!=0.
  - Saturates at all-ones; never wraps.
  - Cleared only by reset.
- Reset asserted mid-flush: flush drops immediately (async) and the FSM returns to RUN.

Test Plan:
- Reset low, all requests high → stall=0, flush=0, stall_cnt_o=0; release reset → stall=6'b011111 the same cycle.
- stallreq_id=1 and stallreq_ex=1 together → stall=6'b001111; drop ex → 6'b000111; after 5 stalled cycles stall_cnt_o=5.
- excepttype_i=32'h8, mtvec_i=32'h100 at cycle N → flush=1, new_pc=32'h100 in N+1 only; stall=0 in N+1 even with stallreq_mem=1.
- excepttype_i=32'he, mepc_i=32'h2040 → new_pc=32'h2040 for one cycle; report held high during FLUSH gives no second flush.
- WDOG_LIMIT=4, stallreq_mem held → flush=1, wdog_trap_o=1, new_pc=mtvec_i after the 4th stalled cycle; same run with excepttype_i=32'ha on the firing edge → wdog_trap_o=0.
- CNT_W=4, stall held 20 cycles → stall_cnt_o saturates at 4'hf and stays there.
